// File: rtl/dispatch_mem_ctl_if.sv
// Bus bundle between the dispatch memory controller and its two requesters:
// the CPU lookup path and the host/debug access path.
//
// Handshakes:
//   cpu  - no flow control. cpu_rd_req is a per-cycle request; cpu_valid
//          rises exactly one cycle later with cpu_data.
//   host - four-phase. Requester raises host_req with host_wr/host_addr/
//          host_wdata stable; controller raises host_ack when the access is
//          done (read data already in host_rdata); requester drops host_req;
//          controller drops host_ack; only then may a new host_req start.
interface dispatch_mem_ctl_if #(
  parameter int AW = 11,
  parameter int DW = 17
);
  logic          cpu_rd_req;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;
  logic          cpu_valid;

  logic          host_req;
  logic          host_wr;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;

  modport master (
    output cpu_rd_req, cpu_addr, host_req, host_wr, host_addr, host_wdata,
    input  cpu_data, cpu_valid, host_ack, host_rdata
  );

  modport slave (
    input  cpu_rd_req, cpu_addr, host_req, host_wr, host_addr, host_wdata,
    output cpu_data, cpu_valid, host_ack, host_rdata
  );
endinterface

// File: rtl/dispatch_mem_ctl.sv
// Dispatch RAM controller. Port A of the dual-port RAM is a read-only CPU
// lookup path passed straight through. Port B is shared between host/debug
// single-word accesses and a full-memory clear engine, sequenced by one FSM.
module dispatch_mem_ctl #(
  parameter int AW = 11,
  parameter int DW = 17
) (
  input  logic          clk,
  input  logic          reset,
  dispatch_mem_ctl_if.slave bus,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic [AW-1:0] ram_addr_a,
  output logic          ram_rden_a,
  output logic [AW-1:0] ram_addr_b,
  output logic [DW-1:0] ram_data_b,
  output logic          ram_wren_b,
  output logic          ram_rden_b,
  input  logic [DW-1:0] ram_q_a,
  input  logic [DW-1:0] ram_q_b,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_WR    = 3'd2,
    S_RD    = 3'd3,
    S_RDW   = 3'd4,
    S_ACK   = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [DW-1:0] rdata_q;
  logic          ack_q;
  logic          cpu_valid_q;
  logic          host_accept;

  // CPU lookups never wait on the FSM; port A is wired straight through.
  assign ram_addr_a     = bus.cpu_addr;
  assign ram_rden_a     = bus.cpu_rd_req;
  assign bus.cpu_data   = ram_q_a;
  assign bus.cpu_valid  = cpu_valid_q;
  assign bus.host_ack   = ack_q;
  assign bus.host_rdata = rdata_q;
  assign clr_busy       = (state == S_CLEAR);
  assign state_dbg      = state;

  // A clear request in the same IDLE cycle wins; the host request stays
  // pending on its level and is taken once the clear returns to IDLE.
  assign host_accept = (state == S_IDLE) && !clr_start && bus.host_req;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and port-B drive.
  always_comb begin
    state_nxt  = state;
    ram_addr_b = lat_addr;
    ram_data_b = lat_wdata;
    ram_wren_b = 1'b0;
    ram_rden_b = 1'b0;
    case (state)
      S_IDLE: begin
        if (clr_start)         state_nxt = S_CLEAR;
        else if (bus.host_req) state_nxt = bus.host_wr ? S_WR : S_RD;
      end
      S_CLEAR: begin
        ram_addr_b = clr_cnt;
        ram_data_b = '0;
        ram_wren_b = 1'b1;
        if (clr_cnt == {AW{1'b1}}) state_nxt = S_IDLE;
      end
      S_WR: begin
        ram_wren_b = 1'b1;
        state_nxt  = S_ACK;
      end
      S_RD: begin
        ram_rden_b = 1'b1;
        state_nxt  = S_RDW;
      end
      S_RDW: state_nxt = S_ACK;
      S_ACK: begin
        // Leave only after the requester has seen ack and released req.
        if (ack_q && !bus.host_req) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Clear address counter: parked at 0 in IDLE, steps once per CLEAR cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  clr_cnt <= '0;
    else if (state == S_IDLE)   clr_cnt <= '0;
    else if (state == S_CLEAR)  clr_cnt <= clr_cnt + 1'b1;
  end

  // Host address/data captured on the accept edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (host_accept) begin
      lat_addr  <= bus.host_addr;
      lat_wdata <= bus.host_wdata;
    end
  end

  // Read data is taken from RAM port B on the RDW exit edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               rdata_q <= '0;
    else if (state == S_RDW) rdata_q <= ram_q_b;
  end

  // host_ack rises one cycle into ACK and falls on the edge that leaves ACK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               ack_q <= 1'b0;
    else if (state == S_ACK) ack_q <= !(ack_q && !bus.host_req);
    else                     ack_q <= 1'b0;
  end

  // cpu_valid is the CPU request delayed by the RAM read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cpu_valid_q <= 1'b0;
    else       cpu_valid_q <= bus.cpu_rd_req;
  end

endmodule
